// File: rtl/hzd_unit_pkg.sv
// Shared types for the MINAv2 hazard unit: register address, 32-bit word,
// instruction hazard class and long-op scoreboard sizing.
package hzd_unit_pkg;

    typedef logic [4:0]  regaddr_t;
    typedef logic [31:0] u32_t;

    localparam int REG_W        = $bits(regaddr_t);
    localparam int NREGS        = 2 ** REG_W;
    localparam int BUSY_W       = 3;
    localparam int HZD_MAX_LONG = 7;

    typedef logic [NREGS-1:0]  pend_vec_t;
    typedef logic [BUSY_W-1:0] busy_t;

    typedef enum logic [1:0] {
        HZD_NONE = 2'd0,
        HZD_ALU  = 2'd1,
        HZD_LOAD = 2'd2,
        HZD_LONG = 2'd3
    } hzd_kind_e;

endpackage

// File: rtl/hzd_unit_scoreboard.sv
// Per-register pending bits and outstanding-count for long-latency ops.
// A set and a clear of the same register in one cycle leave the bit set.
module hzd_unit_scoreboard
    import hzd_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_set,
    input  regaddr_t  i_set_addr,
    input  logic      i_inc,
    input  logic      i_clr,
    input  regaddr_t  i_clr_addr,
    output pend_vec_t o_pending,
    output busy_t     o_busy_cnt,
    output logic      o_err
);

    pend_vec_t r_pending;
    busy_t     r_busy;
    logic      r_err;

    pend_vec_t w_pending_nxt;
    busy_t     w_busy_nxt;
    logic      w_dec;
    logic      w_bad_clr;

    always_comb begin
        // NOTE: every comb output is defaulted first so no path can infer a latch.
        w_pending_nxt = r_pending;
        w_busy_nxt    = r_busy;
        w_dec         = i_clr & (r_busy != '0);
        w_bad_clr     = i_clr & ((r_busy == '0) |
                        (~r_pending[i_clr_addr] & ~(i_set & (i_set_addr == i_clr_addr))));

        if (i_clr) w_pending_nxt[i_clr_addr] = 1'b0;
        if (i_set) w_pending_nxt[i_set_addr] = 1'b1;

        case ({i_inc, w_dec})
            2'b10:   w_busy_nxt = r_busy + 3'd1;
            2'b01:   w_busy_nxt = r_busy - 3'd1;
            default: w_busy_nxt = r_busy;
        endcase
    end

    // NOTE: the pending vector is plain flops, not a RAM, so it resets with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_busy    <= '0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            r_pending <= w_pending_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= r_err | w_bad_clr;
        end
    end

    assign o_pending  = r_pending;
    assign o_busy_cnt = r_busy;
    assign o_err      = r_err;

endmodule

// File: rtl/hzd_unit.sv
// Hazard unit: stalls ID on load-use or on operands/destinations still owned
// by an in-flight multiply/divide, and bubbles ID/EX on stall or flush.
module hzd_unit
    import hzd_unit_pkg::*;
#(
    parameter int LONG_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      id_valid,
    input  hzd_kind_e id_kind,
    input  logic      id_rd_we,
    input  regaddr_t  id_rd_addr,
    input  logic      id_ra_used,
    input  logic      id_rb_used,
    input  regaddr_t  id_ra_addr,
    input  regaddr_t  id_rb_addr,
    input  logic      flush,
    input  logic      lu_done,
    input  regaddr_t  lu_rd_addr,
    output logic      stall,
    output logic      bubble,
    output pend_vec_t pending,
    output busy_t     busy_cnt,
    output u32_t      stall_cycles,
    output logic      err
);

    logic      r_ld_valid;
    regaddr_t  r_ld_rd;
    u32_t      r_stall_cycles;

    pend_vec_t w_pending;
    busy_t     w_busy;
    logic      w_load_use;
    logic      w_raw_long;
    logic      w_waw_long;
    logic      w_full_long;
    logic      w_stall;
    logic      w_issue;
    logic      w_long_issue;

    assign w_load_use  = id_valid & r_ld_valid &
                         ((id_ra_used & (id_ra_addr == r_ld_rd)) |
                          (id_rb_used & (id_rb_addr == r_ld_rd)));
    assign w_raw_long  = id_valid & ((id_ra_used & w_pending[id_ra_addr]) |
                                     (id_rb_used & w_pending[id_rb_addr]));
    assign w_waw_long  = id_valid & id_rd_we & w_pending[id_rd_addr];
    assign w_full_long = id_valid & (id_kind == HZD_LONG) &
                         (w_busy == BUSY_W'(LONG_DEPTH));

    assign w_stall      = ~flush & (w_load_use | w_raw_long | w_waw_long | w_full_long);
    assign w_issue      = id_valid & ~w_stall & ~flush;
    assign w_long_issue = w_issue & (id_kind == HZD_LONG);

    hzd_unit_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set      (w_long_issue & id_rd_we),
        .i_set_addr (id_rd_addr),
        .i_inc      (w_long_issue),
        .i_clr      (lu_done),
        .i_clr_addr (lu_rd_addr),
        .o_pending  (w_pending),
        .o_busy_cnt (w_busy),
        .o_err      (err)
    );

    // A stalled or flushed load never reaches ID/EX, so it is dropped here too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_valid     <= 1'b0;
            r_ld_rd        <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_ld_valid     <= w_issue & (id_kind == HZD_LOAD) & id_rd_we;
            r_ld_rd        <= id_rd_addr;
            r_stall_cycles <= r_stall_cycles + u32_t'(w_stall);
        end
    end

    assign stall        = w_stall;
    assign bubble       = w_stall | flush;
    assign pending      = w_pending;
    assign busy_cnt     = w_busy;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hzd_unit.sv
// Scenario bench for hzd_unit: each cycle's expected outputs are queued as
// stimulus is driven and popped at the following falling edge.
module tb_hzd_unit;
    import hzd_unit_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      id_valid;
    hzd_kind_e id_kind;
    logic      id_rd_we;
    regaddr_t  id_rd_addr;
    logic      id_ra_used;
    logic      id_rb_used;
    regaddr_t  id_ra_addr;
    regaddr_t  id_rb_addr;
    logic      flush;
    logic      lu_done;
    regaddr_t  lu_rd_addr;
    logic      stall;
    logic      bubble;
    pend_vec_t pending;
    busy_t     busy_cnt;
    u32_t      stall_cycles;
    logic      err;

    typedef struct {
        string     nm;
        logic      stall;
        logic      bubble;
        pend_vec_t pend;
        busy_t     busy;
        u32_t      scyc;
        logic      err;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;
    u32_t exp_scyc = 0;

    hzd_unit #(.LONG_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_kind      (id_kind),
        .id_rd_we     (id_rd_we),
        .id_rd_addr   (id_rd_addr),
        .id_ra_used   (id_ra_used),
        .id_rb_used   (id_rb_used),
        .id_ra_addr   (id_ra_addr),
        .id_rb_addr   (id_rb_addr),
        .flush        (flush),
        .lu_done      (lu_done),
        .lu_rd_addr   (lu_rd_addr),
        .stall        (stall),
        .bubble       (bubble),
        .pending      (pending),
        .busy_cnt     (busy_cnt),
        .stall_cycles (stall_cycles),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input hzd_kind_e k, input logic we, input regaddr_t rd,
                         input logic rau, input regaddr_t ra, input logic rbu, input regaddr_t rb,
                         input logic fl, input logic lud, input regaddr_t lur);
        id_valid   = v;
        id_kind    = k;
        id_rd_we   = we;
        id_rd_addr = rd;
        id_ra_used = rau;
        id_ra_addr = ra;
        id_rb_used = rbu;
        id_rb_addr = rb;
        flush      = fl;
        lu_done    = lud;
        lu_rd_addr = lur;
    endtask

    task automatic idle();
        drive(1'b0, HZD_NONE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    // Queue what this cycle must show; stall_cycles counts every earlier stall.
    task automatic push_exp(input string nm, input logic s, input logic b,
                            input pend_vec_t p, input busy_t bc, input logic er);
        q.push_back('{nm, s, b, p, bc, exp_scyc, er});
        if (s) exp_scyc++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            flush = (i == 0);
            push_exp($sformatf("reset_%0d", i), 1'b0, (i == 0), '0, 3'd0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            n_total++;
            if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
                {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
                $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                         e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                         e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
            else n_pass++;
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, HZD_LOAD, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            else        drive(1'b1, HZD_ALU,  1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            push_exp($sformatf("load_use_%0d", i), (i == 1), (i == 1), '0, 3'd0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            n_total++;
            if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
                {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
                $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                         e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                         e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_long_raw();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b1, HZD_LONG, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            else        drive(1'b1, HZD_ALU,  1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, (i == 4), 5'd5);
            if (i == 0)      push_exp("long_raw_0", 1'b0, 1'b0, '0, 3'd0, 1'b0);
            else if (i < 5)  push_exp($sformatf("long_raw_%0d", i), 1'b1, 1'b1, 32'h20, 3'd1, 1'b0);
            else             push_exp("long_raw_5", 1'b0, 1'b0, '0, 3'd0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            n_total++;
            if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
                {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
                $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                         e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                         e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_long_full();
        logic      t_v   [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        regaddr_t  t_rd  [8] = '{5'd1, 5'd2, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0};
        logic      t_lud [8] = '{0, 0, 0, 1, 0, 1, 1, 0};
        regaddr_t  t_lur [8] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd4, 5'd0};
        logic      t_s   [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        pend_vec_t t_p   [8] = '{32'h0, 32'h2, 32'h6, 32'h6, 32'h4, 32'h14, 32'h10, 32'h0};
        busy_t     t_bc  [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 8; i++) begin
            drive(t_v[i], t_v[i] ? HZD_LONG : HZD_NONE, t_v[i], t_rd[i],
                  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, t_lud[i], t_lur[i]);
            push_exp($sformatf("long_full_%0d", i), t_s[i], t_s[i], t_p[i], t_bc[i], 1'b0);
            @(negedge clk);
            e = q.pop_front();
            n_total++;
            if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
                {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
                $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                         e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                         e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, HZD_LOAD, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            else        drive(1'b1, HZD_ALU,  1'b1, 5'd8, 1'b1, 5'd7, 1'b0, 5'd0, (i == 1), 1'b0, 5'd0);
            push_exp($sformatf("flush_%0d", i), 1'b0, (i == 1), '0, 3'd0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            n_total++;
            if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
                {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
                $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                         e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                         e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_err();
        for (int i = 0; i < 3; i++) begin
            idle();
            lu_done    = (i == 0);
            lu_rd_addr = 5'd9;
            push_exp($sformatf("err_%0d", i), 1'b0, 1'b0, '0, 3'd0, (i != 0));
            @(negedge clk);
            e = q.pop_front();
            n_total++;
            if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
                {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
                $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                         e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                         e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, HZD_LONG, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        next_cycle();
        drive(1'b1, HZD_ALU, 1'b1, 5'd3, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        #1;
        n_total++;
        if ({stall, pending, busy_cnt} !== {1'b1, 32'h4, 3'd1})
            $display("FAIL areset_pre: got s=%b p=%h busy=%0d, want s=1 p=00000004 busy=1",
                     stall, pending, busy_cnt);
        else n_pass++;
        #1;
        rst      = 1'b1;
        exp_scyc = 0;
        push_exp("areset_mid", 1'b0, 1'b0, '0, 3'd0, 1'b0);
        @(negedge clk);
        e = q.pop_front();
        n_total++;
        if ({stall, bubble, pending, busy_cnt, stall_cycles, err} !==
            {e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err})
            $display("FAIL %s: got s=%b b=%b p=%h busy=%0d sc=%0d err=%b, want s=%b b=%b p=%h busy=%0d sc=%0d err=%b",
                     e.nm, stall, bubble, pending, busy_cnt, stall_cycles, err,
                     e.stall, e.bubble, e.pend, e.busy, e.scyc, e.err);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_long_raw();
        test_long_full();
        test_flush();
        test_err();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
